apb_timer: RTL and testbench
============================

# apb_timer

APB slave timer peripheral that sits on one PSELx slot of the APB master. It occupies one 4 KB window; the master decodes the window and this block decodes the low address bits. It provides a 32-bit prescaler, a 32-bit up-counter with auto-reload or one-shot mode, a sticky match flag, and a level interrupt. Every register access completes with exactly one wait state.

## Interface
- No parameters. All register widths are fixed at 32 bits.
- PCLK — input, 1 bit: the single clock.
- PRESET — input, 1 bit: reset, asynchronous and active-high. Every flop clears when PRESET rises.
- PADDR — input, 5 bits: byte offset. Connects to master PADDR[4:0].
- PWDATA — input, 32 bits: write data.
- PWRITE — input, 1 bit: 1 = write, 0 = read.
- PENABLE — input, 1 bit: APB access phase.
- PSEL — input, 1 bit: slave select from the master decoder.
- PRDATA — output, 32 bits: read data, registered.
- PREADY — output, 1 bit: transfer complete, registered.
- irq — output, 1 bit: level interrupt, equal to STATUS.match & CTRL.irq_en.

## Operation
- Register map:
  - 0x00 CTRL, R/W:
    - bit0 en: counter runs.
    - bit1 clr: write-only. Reads 0.
    - bit2 irq_en.
    - bit3 auto: 1 = auto-reload, 0 = one-shot.
  - 0x04 PSC, R/W: prescaler value.
  - 0x08 ARR, R/W: compare / reload value.
  - 0x0C CNT, read-only. Writes are ignored.
  - 0x10 STATUS: bit0 match, write-1-to-clear. Other bits read 0.
  - Any other offset: reads 0, writes ignored. PADDR[1:0] is ignored.
- APB handshake:
  - PREADY next = PSEL & PENABLE & ~PREADY.
  - The slave therefore answers in the second ACCESS cycle and drops PREADY the following cycle.
  - Commit cycle = PSEL & PENABLE & PREADY. Register writes take effect at the clock edge ending the commit cycle.
  - PRDATA is loaded on the edge that raises PREADY and holds until the next read load.
  - The read value is the register contents at that edge.
- Prescaler:
  - When en=1, psc_cnt increments each cycle.
  - When psc_cnt ≥ PSC, psc_cnt returns to 0 and a tick is generated in that cycle.
  - PSC=0 gives a tick every cycle.
- Counter, on each tick:
  - If CNT ≥ ARR: CNT ← 0, match ← 1, and if auto=0 then en ← 0.
  - Otherwise: CNT ← CNT+1.
- Using ≥ means that writing ARR below the current CNT forces a reload on the next tick instead of a 2^32 wrap.
- Period is (ARR+1)·(PSC+1) cycles. ARR=0 sets match on every tick with CNT held at 0.
- en=0 freezes both CNT and psc_cnt. They keep their values.
- A CTRL write with clr=1 zeroes CNT and psc_cnt in the commit edge. The other CTRL bits are written normally in the same write.
- A one-shot auto-clear of en wins over a CTRL write landing on the same edge only if that write leaves en=0. A write with en=1 wins.
- If match is set by a tick and cleared by a STATUS write on the same edge, set wins and match stays 1.
- Writing 0 to STATUS has no effect.

## Timing
- Reset values: PRDATA=0, PREADY=0, irq=0, CTRL=PSC=ARR=CNT=0, psc_cnt=0, match=0.
- Transfer length seen by the master: SETUP 1 cycle + ACCESS 2 cycles.
- PREADY is never high for two consecutive cycles.
- Enable latency: the first tick can occur in the cycle after the commit edge that set en.
- irq is combinational from registered match and irq_en, so it rises in the same cycle match rises.
- Reset mid-transfer: PREADY drops immediately and no write commits. The master re-issues the transfer after reset.

## Test plan
- Reset and defaults: assert PRESET mid-ACCESS → PREADY=0 immediately; reads of 0x00/0x04/0x08/0x0C/0x10 all return 0; irq=0.
- Register access and wait state:
  - write ARR=0x0000_00FF → PREADY high exactly one cycle, in the second ACCESS cycle.
  - read 0x08 → 0xFF; read 0x14 → 0; write to 0x0C → CNT unchanged.
- Auto-reload period:
  - PSC=0, ARR=3, CTRL=0xD (en | irq_en | auto) → CNT sequence 1,2,3,0.
  - match and irq rise 4 cycles after the commit edge and remain high.
  - CNT repeats with period 4.
- One-shot with prescaler:
  - PSC=1, ARR=2, CTRL=0x1 → match after 6 cycles.
  - en reads back 0, CNT frozen at 0, irq=0 because irq_en=0.
- W1C and collision:
  - write STATUS=1 while match is set with no tick that cycle → match=0 and irq falls.
  - repeat with ARR=0, PSC=0 so a tick sets match on the commit edge → match stays 1.
- Clear and ARR shrink:
  - while running at CNT=10, write CTRL with clr=1|en|auto → CNT=0 next cycle.
  - run to CNT=10, then write ARR=5 → next tick reloads CNT to 0 and sets match.

Source files
------------

// File: rtl/apb_timer_if.sv
// rtl/apb_timer_if.sv - APB bus bundle between the master slot and the timer
interface apb_timer_if;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_timer.sv
// rtl/apb_timer.sv - APB timer: prescaler, auto-reload/one-shot counter, sticky match, irq
module apb_timer (
    input  logic       PCLK,
    input  logic       PRESET,
    apb_timer_if.slave bus,
    output logic       irq
);
    logic [31:0] psc_q;
    logic [31:0] arr_q;
    logic [31:0] cnt_q;
    logic [31:0] psc_cnt_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_mux;
    logic        en_q;
    logic        irq_en_q;
    logic        auto_q;
    logic        match_q;
    logic        ready_q;

    logic [2:0]  reg_sel;
    logic        access;
    logic        commit_wr;
    logic        wr_ctrl;
    logic        wr_psc;
    logic        wr_arr;
    logic        wr_status;
    logic        tick;
    logic        wrap;
    logic        unused_addr_lsb;

    // Word offset only; the byte lanes inside a word are don't-care.
    assign reg_sel         = bus.PADDR[4:2];
    assign unused_addr_lsb = ^bus.PADDR[1:0];

    assign access    = bus.PSEL & bus.PENABLE;
    assign commit_wr = access & ready_q & bus.PWRITE;
    assign wr_ctrl   = commit_wr & (reg_sel == 3'd0);
    assign wr_psc    = commit_wr & (reg_sel == 3'd1);
    assign wr_arr    = commit_wr & (reg_sel == 3'd2);
    assign wr_status = commit_wr & (reg_sel == 3'd4);

    // A tick fires when the prescaler has reached PSC; >= so a shrunk PSC recovers at once.
    assign tick = en_q & (psc_cnt_q >= psc_q);
    // >= against ARR turns a shrunk ARR into an immediate reload rather than a long wrap.
    assign wrap = tick & (cnt_q >= arr_q);

    assign irq        = match_q & irq_en_q;
    assign bus.PREADY = ready_q;
    assign bus.PRDATA = rdata_q;

    // Read-back mux; clr is write-only so its bit position reads 0.
    always_comb begin
        rd_mux = 32'd0;
        case (reg_sel)
            3'd0:    rd_mux = {28'd0, auto_q, irq_en_q, 1'b0, en_q};
            3'd1:    rd_mux = psc_q;
            3'd2:    rd_mux = arr_q;
            3'd3:    rd_mux = cnt_q;
            3'd4:    rd_mux = {31'd0, match_q};
            default: rd_mux = 32'd0;
        endcase
    end

    // One wait state: PREADY rises in the second access cycle; read data is captured on that edge.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ready_q <= access & ~ready_q;
            if (access & ~ready_q & ~bus.PWRITE) begin
                rdata_q <= rd_mux;
            end
        end
    end

    // Control and limit registers; a CTRL write overrides the one-shot auto-clear of en.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            auto_q   <= 1'b0;
            psc_q    <= 32'd0;
            arr_q    <= 32'd0;
        end else begin
            if (wr_ctrl) begin
                en_q     <= bus.PWDATA[0];
                irq_en_q <= bus.PWDATA[2];
                auto_q   <= bus.PWDATA[3];
            end else if (wrap & ~auto_q) begin
                en_q <= 1'b0;
            end
            if (wr_psc) begin
                psc_q <= bus.PWDATA;
            end
            if (wr_arr) begin
                arr_q <= bus.PWDATA;
            end
        end
    end

    // Prescaler and main counter; clr takes priority over counting on the same edge.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            psc_cnt_q <= 32'd0;
            cnt_q     <= 32'd0;
        end else if (wr_ctrl & bus.PWDATA[1]) begin
            psc_cnt_q <= 32'd0;
            cnt_q     <= 32'd0;
        end else if (en_q) begin
            psc_cnt_q <= tick ? 32'd0 : psc_cnt_q + 32'd1;
            if (tick) begin
                cnt_q <= wrap ? 32'd0 : cnt_q + 32'd1;
            end
        end
    end

    // Sticky match flag; a set from a wrap beats a simultaneous write-1-to-clear.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            match_q <= 1'b0;
        end else begin
            match_q <= wrap | (match_q & ~(wr_status & bus.PWDATA[0]));
        end
    end
endmodule

// File: tb/tb_apb_timer.sv
// tb/tb_apb_timer.sv - directed self-checking bench for apb_timer
module tb_apb_timer;
    logic        PCLK;
    logic        PRESET;
    logic        irq;
    logic [31:0] rd;
    int          n_total;
    int          n_bad;

    apb_timer_if bus ();

    apb_timer dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus),
        .irq    (irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic apb_wr(input logic [4:0] a, input logic [31:0] d);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = a;
        bus.PWDATA  = d;
        step(1);
        bus.PENABLE = 1'b1;
        chk("wr_ready_access1", {31'd0, bus.PREADY}, 32'd0);
        step(1);
        chk("wr_ready_access2", {31'd0, bus.PREADY}, 32'd1);
        step(1);
        chk("wr_ready_after", {31'd0, bus.PREADY}, 32'd0);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    task automatic apb_rd(input logic [4:0] a, output logic [31:0] d);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = a;
        step(1);
        bus.PENABLE = 1'b1;
        step(1);
        chk("rd_ready", {31'd0, bus.PREADY}, 32'd1);
        d = bus.PRDATA;
        step(1);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        PRESET      = 1'b1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 5'd0;
        bus.PWDATA  = 32'd0;
        step(2);
        PRESET = 1'b0;
        chk("reset_pready", {31'd0, bus.PREADY}, 32'd0);
        chk("reset_prdata", bus.PRDATA, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);

        // reset lands in the second access cycle of an ARR write
        bus.PSEL    = 1'b1;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 5'h08;
        bus.PWDATA  = 32'h55;
        step(1);
        bus.PENABLE = 1'b1;
        step(1);
        chk("rst_pre_ready", {31'd0, bus.PREADY}, 32'd1);
        PRESET = 1'b1;
        #1;
        chk("rst_ready_drop", {31'd0, bus.PREADY}, 32'd0);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        step(2);
        PRESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apb_rd(5'(i * 4), rd);
            chk($sformatf("reset_reg_%0d", i * 4), rd, 32'd0);
        end
        chk("reset_irq2", {31'd0, irq}, 32'd0);

        // register access
        apb_wr(5'h08, 32'h0000_00FF);
        apb_rd(5'h08, rd);  chk("arr_rb", rd, 32'h0000_00FF);
        apb_rd(5'h14, rd);  chk("unmapped_rd", rd, 32'd0);
        apb_wr(5'h0C, 32'h1234);
        apb_rd(5'h0C, rd);  chk("cnt_ro", rd, 32'd0);
        apb_wr(5'h00, 32'hE);
        apb_rd(5'h00, rd);  chk("ctrl_rb_clr0", rd, 32'hC);

        // auto-reload, PSC=0 ARR=3: CNT after edge k is k mod 4
        apb_wr(5'h04, 32'd0);
        apb_wr(5'h08, 32'd3);
        apb_wr(5'h00, 32'hD);
        chk("auto_irq_e0", {31'd0, irq}, 32'd0);
        step(3);
        chk("auto_irq_e3", {31'd0, irq}, 32'd0);
        step(1);
        chk("auto_irq_e4", {31'd0, irq}, 32'd1);
        apb_rd(5'h0C, rd);  chk("auto_cnt_k5", rd, 32'd1);
        step(2);
        apb_rd(5'h0C, rd);  chk("auto_cnt_k10", rd, 32'd2);
        step(2);
        apb_rd(5'h0C, rd);  chk("auto_cnt_k15", rd, 32'd3);
        step(2);
        apb_rd(5'h0C, rd);  chk("auto_cnt_k20", rd, 32'd0);
        apb_rd(5'h10, rd);  chk("auto_match", rd, 32'd1);
        chk("auto_irq_hold", {31'd0, irq}, 32'd1);

        // write-1-to-clear with timer stopped
        apb_wr(5'h00, 32'h4);
        chk("w1c_irq_pre", {31'd0, irq}, 32'd1);
        apb_wr(5'h10, 32'd0);
        chk("w1c_zero_noeffect", {31'd0, irq}, 32'd1);
        apb_wr(5'h10, 32'd1);
        chk("w1c_irq_fall", {31'd0, irq}, 32'd0);
        apb_rd(5'h10, rd);  chk("w1c_status", rd, 32'd0);

        // set beats clear when a tick wraps on the commit edge
        apb_wr(5'h08, 32'd0);
        apb_wr(5'h00, 32'hD);
        apb_wr(5'h10, 32'd1);
        chk("collision_irq", {31'd0, irq}, 32'd1);
        apb_rd(5'h10, rd);  chk("collision_status", rd, 32'd1);
        apb_wr(5'h00, 32'h2);
        apb_wr(5'h10, 32'd1);
        apb_rd(5'h10, rd);  chk("stop_status", rd, 32'd0);
        apb_rd(5'h0C, rd);  chk("stop_cnt", rd, 32'd0);

        // one-shot PSC=1 ARR=2: match lands on edge 6
        apb_wr(5'h04, 32'd1);
        apb_wr(5'h08, 32'd2);
        apb_wr(5'h00, 32'h1);
        step(4);
        apb_rd(5'h10, rd);  chk("oneshot_k5", rd, 32'd0);
        apb_rd(5'h10, rd);  chk("oneshot_match", rd, 32'd1);
        apb_rd(5'h00, rd);  chk("oneshot_en_off", rd, 32'd0);
        apb_rd(5'h0C, rd);  chk("oneshot_cnt", rd, 32'd0);
        chk("oneshot_irq", {31'd0, irq}, 32'd0);
        step(5);
        apb_rd(5'h0C, rd);  chk("oneshot_frozen", rd, 32'd0);

        // clr while running, then ARR shrink below CNT
        apb_wr(5'h10, 32'd1);
        apb_wr(5'h04, 32'd0);
        apb_wr(5'h08, 32'd100);
        apb_wr(5'h00, 32'h9);
        step(8);
        apb_wr(5'h00, 32'hB);
        apb_rd(5'h0C, rd);  chk("clr_cnt", rd, 32'd1);
        apb_rd(5'h10, rd);  chk("clr_nomatch", rd, 32'd0);
        step(2);
        apb_wr(5'h08, 32'd5);
        apb_rd(5'h0C, rd);  chk("shrink_cnt", rd, 32'd0);
        apb_rd(5'h10, rd);  chk("shrink_match", rd, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
